// File: rtl/uart_fft_tx.sv
// Streams FFT_SIZE 16-bit result words from RAM as back-to-back UART frames,
// low byte first, prefetching word k+1 while the high byte of word k is sent.
module uart_fft_tx #(
  parameter int FFT_SIZE     = 1024,
  parameter int ADDR_W       = $clog2(FFT_SIZE),
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk_100,
  input  logic              sb0,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic              uart_out,
  output logic              busy,
  output logic              done
);

  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int TICK_W    = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;

  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_CLKS - 1);
  localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(FFT_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state;
  logic [TICK_W-1:0]   r_tick;
  logic [TICK_W-1:0]   w_tick;
  logic [2:0]          r_bit;
  logic [2:0]          w_bit;
  logic                r_hi;
  logic                w_hi;
  logic [ADDR_W-1:0]   r_word;
  logic [ADDR_W-1:0]   w_word;
  logic [15:0]         r_buf;
  logic [15:0]         w_buf;
  logic [15:0]         r_pref;
  logic                r_pref_cap;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_uart;
  logic                r_busy;
  logic                r_done;

  logic                w_rd;
  logic                w_pref;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_uart;
  logic                w_busy;
  logic                w_done;
  logic                w_last;
  logic [7:0]          w_byte;

  assign w_last = (r_word == WORD_LAST);
  assign w_byte = r_hi ? r_buf[15:8] : r_buf[7:0];

  assign mem_rd   = w_rd;
  assign mem_addr = w_addr;
  assign uart_out = r_uart;
  assign busy     = r_busy;
  assign done     = r_done;

  always_ff @(posedge clk_100 or negedge sb0) begin
    if (!sb0) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Next-state logic; the line, busy and done values computed here are
  // registered, so the serial line trails the state by exactly one cycle.
  always_comb begin
    w_state = r_state;
    w_tick  = r_tick;
    w_bit   = r_bit;
    w_hi    = r_hi;
    w_word  = r_word;
    w_buf   = r_buf;
    w_rd    = 1'b0;
    w_pref  = 1'b0;
    w_addr  = r_addr;
    w_uart  = 1'b1;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        // A start coinciding with the done pulse is deliberately ignored.
        if (start && !r_done) begin
          w_rd    = 1'b1;
          w_addr  = {ADDR_W{1'b0}};
          w_busy  = 1'b1;
          w_word  = {ADDR_W{1'b0}};
          w_state = S_LOAD;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_LOAD: begin
        w_buf   = mem_data;
        w_hi    = 1'b0;
        w_tick  = {TICK_W{1'b0}};
        w_bit   = 3'd0;
        w_state = S_START;
      end
      S_START: begin
        w_uart = 1'b0;
        if (r_hi && (r_tick == {TICK_W{1'b0}}) && !w_last) begin
          w_rd   = 1'b1;
          w_pref = 1'b1;
          w_addr = r_word + ADDR_W'(1);
        end else begin
          w_rd   = 1'b0;
        end
        if (r_tick == BIT_LAST) begin
          w_tick  = {TICK_W{1'b0}};
          w_bit   = 3'd0;
          w_state = S_DATA;
        end else begin
          w_tick  = r_tick + TICK_W'(1);
        end
      end
      S_DATA: begin
        w_uart = w_byte[r_bit];
        if (r_tick == BIT_LAST) begin
          w_tick = {TICK_W{1'b0}};
          if (r_bit == 3'd7) begin
            w_state = S_STOP;
          end else begin
            w_bit   = r_bit + 3'd1;
          end
        end else begin
          w_tick = r_tick + TICK_W'(1);
        end
      end
      S_STOP: begin
        w_uart = 1'b1;
        if (r_tick == STOP_LAST) begin
          w_tick = {TICK_W{1'b0}};
          if (!r_hi) begin
            w_hi    = 1'b1;
            w_state = S_START;
          end else if (!w_last) begin
            w_buf   = r_pref;
            w_word  = r_word + ADDR_W'(1);
            w_hi    = 1'b0;
            w_state = S_START;
          end else begin
            w_state = S_DONE;
          end
        end else begin
          w_tick = r_tick + TICK_W'(1);
        end
      end
      S_DONE: begin
        w_busy  = 1'b0;
        w_done  = 1'b1;
        w_state = S_IDLE;
      end
      default: begin
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100 or negedge sb0) begin
    if (!sb0) begin
      r_tick     <= {TICK_W{1'b0}};
      r_bit      <= 3'd0;
      r_hi       <= 1'b0;
      r_word     <= {ADDR_W{1'b0}};
      r_buf      <= 16'h0000;
      r_addr     <= {ADDR_W{1'b0}};
      r_pref_cap <= 1'b0;
    end else begin
      r_tick     <= w_tick;
      r_bit      <= w_bit;
      r_hi       <= w_hi;
      r_word     <= w_word;
      r_buf      <= w_buf;
      r_addr     <= w_addr;
      r_pref_cap <= w_pref;
    end
  end

  // Read data arrives one cycle after the prefetch strobe.
  always_ff @(posedge clk_100 or negedge sb0) begin
    if (!sb0) begin
      r_pref <= 16'h0000;
    end else if (r_pref_cap) begin
      r_pref <= mem_data;
    end else begin
      r_pref <= r_pref;
    end
  end

  always_ff @(posedge clk_100 or negedge sb0) begin
    if (!sb0) begin
      r_uart <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_uart <= w_uart;
      r_busy <= w_busy;
      r_done <= w_done;
    end
  end

endmodule

// File: tb/tb_uart_fft_tx.sv
// Bench for uart_fft_tx: two instances (default and CLKS_PER_BIT=4/STOP_BITS=2/FFT_SIZE=2)
// checked every cycle against an arithmetic model of the expected line waveform.
module tb_uart_fft_tx;

  localparam int N1 = 1024, C1 = 1, S1 = 1;
  localparam int N2 = 2,    C2 = 4, S2 = 2;
  localparam int F1 = (9 + S1) * C1;
  localparam int F2 = (9 + S2) * C2;

  logic        clk = 1'b0;
  logic        sb0 = 1'b1;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic        rd1, rd2, line1, line2, busy1, busy2, done1, done2;
  logic [9:0]  addr1;
  logic [0:0]  addr2;
  logic [15:0] md1, md2;
  logic [15:0] ram1 [N1];
  logic [15:0] ram2 [N2];

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;

  bit         act_m [2];
  longint     s_m [2];
  int         rdn [2];
  int         ndone [2];
  longint     done_at [2];
  bit         rx_on [2];
  int         rx_t [2];
  logic [7:0] rx_sh [2];
  logic [7:0] rxq1 [$];
  logic [7:0] rxq2 [$];

  uart_fft_tx dut1 (
    .clk_100(clk), .sb0(sb0), .start(start1), .mem_rd(rd1), .mem_addr(addr1),
    .mem_data(md1), .uart_out(line1), .busy(busy1), .done(done1)
  );

  uart_fft_tx #(.FFT_SIZE(N2), .CLKS_PER_BIT(C2), .STOP_BITS(S2)) dut2 (
    .clk_100(clk), .sb0(sb0), .start(start2), .mem_rd(rd2), .mem_addr(addr2),
    .mem_data(md2), .uart_out(line2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rd1) md1 <= ram1[addr1];
    if (rd2) md2 <= ram2[addr2];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected line level 'off' cycles after the first start bit of a transfer.
  function automatic logic exp_line(input int id, input longint off);
    int n, cpb, fl, f, pos;
    logic [15:0] w;
    logic [7:0]  b;
    n   = id ? N2 : N1;
    cpb = id ? C2 : C1;
    fl  = id ? F2 : F1;
    if (off < 0 || off >= longint'(2 * n * fl)) return 1'b1;
    f   = int'(off / fl);
    pos = int'((off % fl) / cpb);
    w   = id ? ram2[f / 2] : ram1[f / 2];
    b   = (f % 2 == 1) ? w[15:8] : w[7:0];
    if (pos == 0) return 1'b0;
    else if (pos <= 8) return b[pos - 1];
    else return 1'b1;
  endfunction

  task automatic model_step(input int id, input logic st, input logic ln, input logic bz,
                            input logic dn, input logic rd, input int ad);
    longint t_len, off;
    int n, cpb, stp, idx;
    logic e_busy, e_done;
    n     = id ? N2 : N1;
    cpb   = id ? C2 : C1;
    stp   = id ? S2 : S1;
    t_len = 2 * n * (id ? F2 : F1);
    if (!sb0) begin
      act_m[id] = 1'b0;
      rx_on[id] = 1'b0;
      check("reset_line", ln, 1);
      check("reset_busy", bz, 0);
      check("reset_done", dn, 0);
      check("reset_rd", rd, 0);
    end else begin
      if (st && (!act_m[id] || cyc > s_m[id] + t_len + 3)) begin
        act_m[id] = 1'b1;
        s_m[id]   = cyc;
        rdn[id]   = 0;
      end
      off    = act_m[id] ? (cyc - s_m[id] - 3) : -1;
      e_busy = act_m[id] && (cyc >= s_m[id] + 1) && (cyc <= s_m[id] + t_len + 2);
      e_done = act_m[id] && (cyc == s_m[id] + t_len + 3);
      check(id ? "line2" : "line1", ln, exp_line(id, off));
      check(id ? "busy2" : "busy1", bz, e_busy);
      check(id ? "done2" : "done1", dn, e_done);
      if (rd) begin
        check(id ? "rd_addr2" : "rd_addr1", ad, rdn[id]);
        rdn[id]++;
      end
      if (e_done) check(id ? "rd_count2" : "rd_count1", rdn[id], n);
      if (dn) begin
        ndone[id]++;
        done_at[id] = cyc;
      end
      if (rx_on[id]) begin
        rx_t[id]++;
        if (rx_t[id] >= cpb + cpb / 2 && rx_t[id] < 9 * cpb && (rx_t[id] - cpb / 2) % cpb == 0) begin
          idx = (rx_t[id] - cpb / 2) / cpb - 1;
          rx_sh[id][idx] = ln;
        end
        if (rx_t[id] == 9 * cpb + cpb / 2) begin
          check("rx_stop_bit", ln, 1);
          if (id == 0) rxq1.push_back(rx_sh[id]);
          else rxq2.push_back(rx_sh[id]);
        end
        if (rx_t[id] == (9 + stp) * cpb - 1) rx_on[id] = 1'b0;
      end else if (ln == 1'b0) begin
        rx_on[id] = 1'b1;
        rx_t[id]  = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, start1, line1, busy1, done1, rd1, int'(addr1));
    model_step(1, start2, line2, busy2, done2, rd2, int'(addr2));
  end

  function automatic int stream_bad(input int id);
    int bad;
    int sz;
    logic [15:0] w;
    logic [7:0]  e;
    bad = 0;
    sz  = id ? rxq2.size() : rxq1.size();
    for (int i = 0; i < 2 * (id ? N2 : N1); i++) begin
      w = id ? ram2[i / 2] : ram1[i / 2];
      e = (i % 2 == 1) ? w[15:8] : w[7:0];
      if (i >= sz) bad++;
      else if ((id ? rxq2[i] : rxq1[i]) !== e) bad++;
    end
    return bad;
  endfunction

  task automatic wait_done(input int id, input int limit);
    int n0;
    int k;
    n0 = ndone[id];
    k  = 0;
    while (ndone[id] == n0 && k < limit) begin
      @(posedge clk);
      k++;
    end
    check("done_seen", ndone[id] - n0, 1);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N1; i++) ram1[i] = 16'(i * 3 + 32'h1234);
  endtask

  longint s;
  int     bad;
  logic [7:0] e8;

  initial begin
    fill_ramp();
    ram2[0] = 16'hA5C3;
    ram2[1] = 16'h0F01;
    #1 sb0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 sb0 = 1'b1;
    repeat (50) @(posedge clk);
    #1;

    // Ramp transfer with starts during byte 5 and in the done cycle.
    rxq1.delete();
    ndone[0] = 0;
    s = cyc;
    start1 = 1'b1;
    for (int k = 0; k < 20500; k++) begin
      @(posedge clk);
      #1;
      start1 = (cyc == s + 55) || (cyc == s + 20483);
    end
    start1 = 1'b0;
    check("done_pulses", ndone[0], 1);
    check("done_latency", done_at[0] - s, 20483);
    check("rx_count", rxq1.size(), 2048);
    check("byte0", rxq1[0], 8'h34);
    check("byte1", rxq1[1], 8'h12);
    check("byte2", rxq1[2], 8'h37);
    check("byte3", rxq1[3], 8'h12);
    bad = 0;
    for (int i = 0; i < 2 * N1 && i < rxq1.size(); i++) begin
      e8 = (i % 2 == 1) ? 8'(((i / 2) * 3 + 32'h1234) >> 8) : 8'((i / 2) * 3 + 32'h1234);
      if (rxq1[i] !== e8) bad++;
    end
    check("ramp_stream_bad", bad, 0);
    check("busy_after_done", busy1, 0);

    // Random RAM contents.
    for (int i = 0; i < N1; i++) ram1[i] = 16'($urandom);
    rxq1.delete();
    s = cyc;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    wait_done(0, 30000);
    check("rand_stream_bad", stream_bad(0), 0);
    check("rand_done_latency", done_at[0] - s, 20483);

    // Reset during the data bits of byte 7, then restart from word 0.
    fill_ramp();
    s = cyc;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (75) @(posedge clk);
    #3 sb0 = 1'b0;
    #1;
    check("midreset_line", line1, 1);
    check("midreset_busy", busy1, 0);
    @(posedge clk);
    @(posedge clk);
    #1 sb0 = 1'b1;
    @(posedge clk);
    #1;
    rxq1.delete();
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("restart_count_ge2", rxq1.size() >= 2, 1);
    check("restart_byte0", rxq1[0], 8'h34);
    check("restart_byte1", rxq1[1], 8'h12);
    sb0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 sb0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Slow line, two stop bits, two words.
    rxq2.delete();
    s = cyc;
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    wait_done(1, 1000);
    check("p2_count", rxq2.size(), 4);
    check("p2_byte0", rxq2[0], 8'hC3);
    check("p2_byte1", rxq2[1], 8'hA5);
    check("p2_byte2", rxq2[2], 8'h01);
    check("p2_byte3", rxq2[3], 8'h0F);
    check("p2_done_latency", done_at[1] - s, 179);

    for (int r = 0; r < 4; r++) begin
      ram2[0] = 16'($urandom);
      ram2[1] = 16'($urandom);
      rxq2.delete();
      s = cyc;
      start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
      wait_done(1, 1000);
      check("p2_rand_stream_bad", stream_bad(1), 0);
      check("p2_rand_done_latency", done_at[1] - s, 179);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
